// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: collects four BCD digits and loads them as
// the current time or the alarm time, with an inactivity timeout.
module time_entry_ctrl #(
   parameter int unsigned TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic [3:0] key,
   output logic [3:0] new_current_time_ms_hr,
   output logic [3:0] new_current_time_ls_hr,
   output logic [3:0] new_current_time_ms_min,
   output logic [3:0] new_current_time_ls_min,
   output logic       load_new_c,
   output logic       load_new_a,
   output logic       show_new_time,
   output logic       show_a,
   output logic       entry_error
);

   localparam int unsigned TMO_W   = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned DIG_W   = 16;
   localparam logic [3:0] KEY_ALARM = 4'd10;
   localparam logic [3:0] KEY_TIME  = 4'd11;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY      = 2'd1,
      SHOW_ALARM = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DIG_W-1:0]   digits_q, digits_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               load_c_d, load_a_d, err_d, show_new_d, show_a_d;

   logic is_digit, is_alarm, is_time, time_ok, tmo_last;

   assign is_digit = key_valid && (key <= 4'd9);
   assign is_alarm = key_valid && (key == KEY_ALARM);
   assign is_time  = key_valid && (key == KEY_TIME);
   assign tmo_last = (tmo_q == TMO_W'(TIMEOUT_S - 1));

   // Entered digits form a legal 24-hour HH:MM time
   always_comb begin
      time_ok = (digits_q[15:12] <= 4'd2) &&
                ((digits_q[15:12] == 4'd2) ? (digits_q[11:8] <= 4'd3)
                                           : (digits_q[11:8] <= 4'd9)) &&
                (digits_q[7:4] <= 4'd5) && (digits_q[3:0] <= 4'd9);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      load_c_d = 1'b0;
      load_a_d = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (is_digit) begin
               digits_d = {12'd0, key};
               cnt_d    = CNT_W'(1);
               state_d  = ENTRY;
            end else if (is_alarm) begin
               state_d = SHOW_ALARM;
            end
         end
         SHOW_ALARM: begin
            if (is_digit) begin
               digits_d = {12'd0, key};
               cnt_d    = CNT_W'(1);
               state_d  = ENTRY;
            end else if (is_alarm) begin
               state_d = IDLE;
            end else if (is_time) begin
               tmo_d = '0;
            end else if (one_second) begin
               if (tmo_last) state_d = IDLE;
               else          tmo_d   = tmo_q + TMO_W'(1);
            end
         end
         ENTRY: begin
            if (is_digit) begin
               digits_d = {digits_q[11:0], key};
               if (cnt_q != CNT_W'(4)) cnt_d = cnt_q + CNT_W'(1);
               tmo_d = '0;
            end else if (is_time || is_alarm) begin
               state_d = IDLE;
               if ((cnt_q == CNT_W'(4)) && time_ok) begin
                  load_c_d = is_time;
                  load_a_d = is_alarm;
               end else begin
                  err_d = 1'b1;
               end
            end else if (one_second) begin
               if (tmo_last) state_d = IDLE;
               else          tmo_d   = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Any state change restarts the inactivity window
      if (state_d != state_q) tmo_d = '0;

      show_new_d = (state_d == ENTRY);
      show_a_d   = (state_d == SHOW_ALARM);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         digits_q      <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         load_new_c    <= 1'b0;
         load_new_a    <= 1'b0;
         entry_error   <= 1'b0;
         show_new_time <= 1'b0;
         show_a        <= 1'b0;
      end else begin
         state_q       <= state_d;
         digits_q      <= digits_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         load_new_c    <= load_c_d;
         load_new_a    <= load_a_d;
         entry_error   <= err_d;
         show_new_time <= show_new_d;
         show_a        <= show_a_d;
      end
   end

   assign new_current_time_ms_hr  = digits_q[15:12];
   assign new_current_time_ls_hr  = digits_q[11:8];
   assign new_current_time_ms_min = digits_q[7:4];
   assign new_current_time_ls_min = digits_q[3:0];

endmodule
